// File: rtl/qr_pkg.sv
// rtl/qr_pkg.sv - shared widths and unload FSM state encoding for the Q-column unloader
package qr_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_ELEM = 3;
    localparam int IDX_W    = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } unload_state_e;

endpackage

// File: rtl/unload_q.sv
// rtl/unload_q.sv - captures one 3-element Q column and streams it out with a valid/ready handshake
module unload_q
    import qr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] q1,
    input  logic [DATA_W-1:0] q2,
    input  logic [DATA_W-1:0] q3,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              stop
);

    unload_state_e     r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_words [NUM_ELEM];
    logic [DATA_W-1:0] w_sel;
    logic              w_send;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            for (int i = 0; i < NUM_ELEM; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_words[0] <= q1;
                        r_words[1] <= q2;
                        r_words[2] <= q3;
                        r_idx      <= '0;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // idx returns to 0 on the final handshake so idle outputs decode cleanly
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sel = '0;
        case (r_idx)
            2'd0:    w_sel = r_words[0];
            2'd1:    w_sel = r_words[1];
            2'd2:    w_sel = r_words[2];
            default: w_sel = '0;
        endcase
    end

    // Every output decodes from registered state only; no input reaches an output combinationally.
    assign w_send    = (r_state == ST_SEND);
    assign out_valid = w_send;
    assign out_data  = w_send ? w_sel : '0;
    assign out_idx   = w_send ? r_idx : '0;
    assign out_last  = w_send && (r_idx == LAST_IDX);
    assign busy      = (r_state != ST_IDLE);
    assign stop      = (r_state == ST_DONE);

endmodule
